// File: rtl/safe_zone_arbiter_pkg.sv
// Shared game package: screen geometry defaults, arbiter FSM state encoding
// and a bounds helper for query coordinates.
package safe_zone_arbiter_pkg;

   localparam int DEFAULT_SCREEN_WIDTH  = 400;
   localparam int DEFAULT_SCREEN_HEIGHT = 600;
   localparam int DEFAULT_BLOCK_SIZE    = 20;

   typedef logic [2:0] state_t;

   localparam state_t ST_RUN   = 3'd0;
   localparam state_t ST_DRAIN = 3'd1;
   localparam state_t ST_PULSE = 3'd2;
   localparam state_t ST_ARM   = 3'd3;
   localparam state_t ST_WAIT  = 3'd4;

   function automatic logic on_screen(input int x, input int y, input int w, input int h);
      return (x < w) && (y < h);
   endfunction

endpackage

// File: rtl/safe_zone_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last
// accepted grant; the pointer moves only when the grant is consumed.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   localparam logic [IDX_W:0]   N_WIDE = (IDX_W + 1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] win;
   logic [IDX_W:0]   pos;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      grant = '0;
      win   = ptr;
      pos   = '0;
      // Walk from the farthest slot back to ptr so the nearest requester wins last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         pos = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (pos >= N_WIDE) pos = pos - N_WIDE;
         if (req[pos[IDX_W-1:0]]) begin
            grant                   = '0;
            grant[pos[IDX_W-1:0]]   = 1'b1;
            win                     = pos[IDX_W-1:0];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (win == LAST) ? '0 : win + 1'b1;
      end
   end

endmodule

// File: rtl/safe_zone_arbiter.sv
// Arbitrates safe-zone map lookups among NUM_REQ requesters and sequences
// map regeneration (drain, pulse, wait for ready) around the query pipeline.
module safe_zone_arbiter
   import safe_zone_arbiter_pkg::*;
#(
   parameter  int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
   parameter  int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
   parameter  int NUM_REQ       = 4,
   localparam int X_W           = $clog2(SCREEN_WIDTH),
   localparam int Y_W           = $clog2(SCREEN_HEIGHT)
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   i_regen_req,
   output logic                   o_regen_busy,
   output logic                   o_level_valid,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   output logic [NUM_REQ-1:0]     o_req_ready,
   input  logic [NUM_REQ*X_W-1:0] i_req_x,
   input  logic [NUM_REQ*Y_W-1:0] i_req_y,
   output logic [NUM_REQ-1:0]     o_resp_valid,
   output logic                   o_resp_safe,
   output logic                   o_sz_regenerate,
   input  logic                   i_sz_rdy,
   output logic [X_W-1:0]         o_sz_x,
   output logic [Y_W-1:0]         o_sz_y,
   input  logic                   i_sz_is_safe
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             state;
   logic               pending;
   logic               level_valid;
   logic               open_q;
   logic [NUM_REQ-1:0] req_masked;
   logic [NUM_REQ-1:0] grant;
   logic               accept;
   logic [IDX_W-1:0]   grant_idx;
   logic [X_W-1:0]     sel_x;
   logic [Y_W-1:0]     sel_y;
   logic               s1_valid;
   logic               s1_oob;
   logic [IDX_W-1:0]   s1_idx;

   assign open_q     = (state == ST_RUN) && level_valid && !pending;
   assign req_masked = i_req_valid & {NUM_REQ{open_q}};
   assign accept     = |grant;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (clk),
      .arst_n  (arst_n),
      .req     (req_masked),
      .advance (accept),
      .grant   (grant)
   );

   always_comb begin
      grant_idx = '0;
      sel_x     = '0;
      sel_y     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = IDX_W'(i);
            sel_x     = i_req_x[i*X_W +: X_W];
            sel_y     = i_req_y[i*Y_W +: Y_W];
         end
      end
   end

   // Stage 1 drives the map coordinate; stage 2 captures its combinational answer.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         s1_valid     <= 1'b0;
         s1_oob       <= 1'b0;
         s1_idx       <= '0;
         o_sz_x       <= '0;
         o_sz_y       <= '0;
         o_resp_valid <= '0;
         o_resp_safe  <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_idx <= grant_idx;
            s1_oob <= !on_screen(int'(sel_x), int'(sel_y), SCREEN_WIDTH, SCREEN_HEIGHT);
            o_sz_x <= sel_x;
            o_sz_y <= sel_y;
         end
         o_resp_valid <= '0;
         o_resp_safe  <= 1'b0;
         if (s1_valid) begin
            o_resp_valid[s1_idx] <= 1'b1;
            o_resp_safe          <= !s1_oob && i_sz_is_safe;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= ST_RUN;
         pending     <= 1'b0;
         level_valid <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (pending) begin
                  state   <= ST_DRAIN;
                  pending <= 1'b0;
               end else if (i_regen_req) begin
                  pending <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!s1_valid && (o_resp_valid == '0)) state <= ST_PULSE;
            end
            ST_PULSE: begin
               level_valid <= 1'b0;
               state       <= ST_ARM;
            end
            // The map only drops ready a cycle after the pulse, so ARM ignores it.
            ST_ARM: state <= ST_WAIT;
            ST_WAIT: begin
               if (i_sz_rdy) begin
                  level_valid <= 1'b1;
                  state       <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign o_req_ready     = grant;
   assign o_level_valid   = level_valid;
   assign o_sz_regenerate = (state == ST_PULSE);
   assign o_regen_busy    = (state != ST_RUN) || pending;

endmodule

// File: tb/tb_safe_zone_arbiter.sv
// Directed bench for safe_zone_arbiter: per-cycle expectations for control
// outputs plus a queue of expected map coordinates and responses.
module tb_safe_zone_arbiter;

   localparam int NREQ = 4;
   localparam int SW   = 400;
   localparam int SH   = 600;
   localparam int XW   = $clog2(SW);
   localparam int YW   = $clog2(SH);

   typedef struct {
      int          acc;
      int          idx;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic        safe;
   } exp_t;

   logic               clk = 1'b0;
   logic               arst_n;
   logic               regen;
   logic               busy;
   logic               level_valid;
   logic [NREQ-1:0]    valid;
   logic [NREQ-1:0]    ready;
   logic [NREQ*XW-1:0] req_x;
   logic [NREQ*YW-1:0] req_y;
   logic [NREQ-1:0]    resp_valid;
   logic               resp_safe;
   logic               sz_regen;
   logic               sz_rdy;
   logic [XW-1:0]      sz_x;
   logic [YW-1:0]      sz_y;
   logic               sz_safe;
   logic               force_safe;
   logic [XW-1:0]      rx [NREQ];
   logic [YW-1:0]      ry [NREQ];

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic map_safe(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ((int'(x) + int'(y)) % 7) != 0;
   endfunction

   always_comb begin
      req_x = '0;
      req_y = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_x[i*XW +: XW] = rx[i];
         req_y[i*YW +: YW] = ry[i];
      end
   end

   assign sz_safe = force_safe | map_safe(sz_x, sz_y);

   safe_zone_arbiter #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .NUM_REQ(NREQ)) dut (
      .clk             (clk),
      .arst_n          (arst_n),
      .i_regen_req     (regen),
      .o_regen_busy    (busy),
      .o_level_valid   (level_valid),
      .i_req_valid     (valid),
      .o_req_ready     (ready),
      .i_req_x         (req_x),
      .i_req_y         (req_y),
      .o_resp_valid    (resp_valid),
      .o_resp_safe     (resp_safe),
      .o_sz_regenerate (sz_regen),
      .i_sz_rdy        (sz_rdy),
      .o_sz_x          (sz_x),
      .o_sz_y          (sz_y),
      .i_sz_is_safe    (sz_safe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already driven; sample at the falling edge.
   task automatic step(input logic [NREQ-1:0] e_ready, input logic e_regen,
                       input logic e_lv, input logic e_busy);
      exp_t e;
      int   idx;
      @(negedge clk);
      cyc++;
      check("req_ready", 32'(ready), 32'(e_ready));
      check("sz_regenerate", 32'(sz_regen), 32'(e_regen));
      check("level_valid", 32'(level_valid), 32'(e_lv));
      check("regen_busy", 32'(busy), 32'(e_busy));
      if (e_ready != '0) begin
         idx = 0;
         for (int i = 0; i < NREQ; i++) if (e_ready[i]) idx = i;
         e.acc  = cyc;
         e.idx  = idx;
         e.x    = rx[idx];
         e.y    = ry[idx];
         e.safe = (int'(rx[idx]) < SW) && (int'(ry[idx]) < SH) && (force_safe || map_safe(rx[idx], ry[idx]));
         sb.push_back(e);
      end
      foreach (sb[k]) begin
         if (sb[k].acc + 1 == cyc) begin
            check("sz_x", 32'(sz_x), 32'(sb[k].x));
            check("sz_y", 32'(sz_y), 32'(sb[k].y));
         end
      end
      if (sb.size() > 0 && sb[0].acc + 2 == cyc) begin
         e = sb.pop_front();
         check("resp_valid", 32'(resp_valid), 32'(1) << e.idx);
         check("resp_safe", 32'(resp_safe), 32'(e.safe));
      end else begin
         check("resp_idle", 32'(resp_valid), 32'(0));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n     = 1'b0;
      regen      = 1'b0;
      valid      = '0;
      sz_rdy     = 1'b1;
      force_safe = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         rx[i] = '0;
         ry[i] = '0;
      end

      // Reset state
      repeat (2) step(4'b0000, 0, 0, 0);
      check("rst_sz_x", 32'(sz_x), 32'(0));
      check("rst_sz_y", 32'(sz_y), 32'(0));
      check("rst_resp_safe", 32'(resp_safe), 32'(0));
      arst_n = 1'b1;

      // First level generation: RUN(pending) -> DRAIN -> PULSE -> ARM -> WAIT
      regen = 1'b1; step(4'b0000, 0, 0, 0);
      regen = 1'b0; step(4'b0000, 0, 0, 1);
      step(4'b0000, 0, 0, 1);
      step(4'b0000, 1, 0, 1);
      sz_rdy = 1'b0;
      repeat (5) step(4'b0000, 0, 0, 1);
      sz_rdy = 1'b1;
      step(4'b0000, 0, 0, 1);

      // All requesters valid: grants rotate 0,1,2,3,0
      rx[0] = 9'd20; ry[0] = 10'd30;
      rx[1] = 9'd27; ry[1] = 10'd41;
      rx[2] = 9'd34; ry[2] = 10'd52;
      rx[3] = 9'd41; ry[3] = 10'd64;
      valid = 4'b1111;
      for (int k = 0; k < 5; k++) step(4'(1 << (k % 4)), 0, 1, 0);
      valid = 4'b0000;
      repeat (2) step(4'b0000, 0, 1, 0);

      // Out-of-range coordinates respond unsafe even when the map says safe
      force_safe = 1'b1;
      valid = 4'b0010;
      rx[1] = 9'd400; ry[1] = 10'd10;  step(4'b0010, 0, 1, 0);
      rx[1] = 9'd10;  ry[1] = 10'd600; step(4'b0010, 0, 1, 0);
      rx[1] = 9'd399; ry[1] = 10'd599; step(4'b0010, 0, 1, 0);
      valid = 4'b0000;
      repeat (2) step(4'b0000, 0, 1, 0);
      force_safe = 1'b0;

      // Single query from requester 2 at (45,65)
      rx[2] = 9'd45; ry[2] = 10'd65;
      valid = 4'b0100; step(4'b0100, 0, 1, 0);
      valid = 4'b0000;
      repeat (2) step(4'b0000, 0, 1, 0);

      // Regen with two queries in flight; a regen pulse during WAIT is dropped
      rx[0] = 9'd100; ry[0] = 10'd200;
      rx[3] = 9'd7;   ry[3] = 10'd7;
      valid = 4'b1001; step(4'b1000, 0, 1, 0);
      regen = 1'b1;    step(4'b0001, 0, 1, 0);
      regen = 1'b0;    step(4'b0000, 0, 1, 1);
      step(4'b0000, 0, 1, 1);
      step(4'b0000, 0, 1, 1);
      step(4'b0000, 1, 1, 1);
      sz_rdy = 1'b0;   step(4'b0000, 0, 0, 1);
      regen = 1'b1;    step(4'b0000, 0, 0, 1);
      regen = 1'b0; sz_rdy = 1'b1; step(4'b0000, 0, 0, 1);
      step(4'b1000, 0, 1, 0);
      step(4'b0001, 0, 1, 0);
      valid = 4'b0000;
      repeat (2) step(4'b0000, 0, 1, 0);

      // Reset one cycle after an accept discards the in-flight query
      rx[1] = 9'd50; ry[1] = 10'd60;
      valid = 4'b0010; step(4'b0010, 0, 1, 0);
      valid = 4'b0000;
      arst_n = 1'b0;
      sb.delete();
      step(4'b0000, 0, 0, 0);
      check("mid_rst_sz_x", 32'(sz_x), 32'(0));
      check("mid_rst_sz_y", 32'(sz_y), 32'(0));
      check("mid_rst_resp_safe", 32'(resp_safe), 32'(0));
      arst_n = 1'b1;
      valid = 4'b1111;
      repeat (3) step(4'b0000, 0, 0, 0);
      valid = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/safe_zone_arbiter.md
SAFE_ZONE_ARBITER -- requirements
Module: safe_zone_arbiter

Interface
REQ-001 Parameter SCREEN_WIDTH, default 400, screen width in pixels; X_W = clog2(SCREEN_WIDTH).
REQ-002 Parameter SCREEN_HEIGHT, default 600, screen height in pixels; Y_W = clog2(SCREEN_HEIGHT).
REQ-003 Parameter NUM_REQ, default 4, number of query requesters (2..8).
REQ-004 The block SHALL use one clock, clk, and an asynchronous active-low reset, arst_n.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 arst_n  in  1  asynchronous active-low reset.
REQ-007 i_regen_req  in  1  one-cycle pulse requesting a new level.
REQ-008 o_regen_busy  out  1  high while the arbiter is not in RUN.
REQ-009 o_level_valid  out  1  high once at least one regeneration has completed.
REQ-010 i_req_valid  in  NUM_REQ  per-requester query valid.
REQ-011 o_req_ready  out  NUM_REQ  per-requester accept, at most one bit set.
REQ-012 i_req_x  in  NUM_REQ*X_W  packed query x per requester.
REQ-013 i_req_y  in  NUM_REQ*Y_W  packed query y per requester.
REQ-014 o_resp_valid  out  NUM_REQ  one-cycle response strobe per requester.
REQ-015 o_resp_safe  out  1  response data, meaningful only with an o_resp_valid bit.
REQ-016 o_sz_regenerate  out  1  one-cycle regenerate pulse to the safe-zone map.
REQ-017 i_sz_rdy  in  1  safe-zone map ready (low during generation).
REQ-018 o_sz_x / o_sz_y  out  X_W / Y_W  registered lookup coordinate to the map.
REQ-019 i_sz_is_safe  in  1  combinational map lookup result for o_sz_x/o_sz_y.

Function
REQ-020 FSM states SHALL be RUN, DRAIN, PULSE, ARM, WAIT; reset state RUN.
REQ-021 In RUN with o_level_valid=1 and no pending regen, the arbiter SHALL assert o_req_ready for exactly one valid requester, chosen round-robin starting at last grant + 1 (mod NUM_REQ).
REQ-022 A query SHALL be accepted in cycle t when i_req_valid[g] & o_req_ready[g]; one accept per cycle max, full throughput.
REQ-023 Accepted x/y and grant index SHALL be registered onto o_sz_x/o_sz_y at t+1; i_sz_is_safe sampled at end of t+1; o_resp_valid[g] and o_resp_safe asserted in t+2 (latency 2).
REQ-024 Queries with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT SHALL respond o_resp_safe=0 with the same latency, independent of i_sz_is_safe.
REQ-025 o_sz_x/o_sz_y SHALL hold their last value when no query is in flight.
REQ-026 o_req_ready SHALL be all-zero while o_level_valid=0, while a regen is pending, and in any state other than RUN.
REQ-027 i_regen_req in RUN SHALL set a pending flag; the FSM SHALL go RUN->DRAIN the following cycle, and no new query is accepted from the cycle after the pulse.
REQ-028 i_regen_req and a request valid in the same cycle: the query SHALL still be accepted if granted; the regen takes effect next cycle.
REQ-029 DRAIN SHALL last until both pipeline stages are empty (at most 2 cycles), then go to PULSE.
REQ-030 PULSE SHALL assert o_sz_regenerate for exactly one cycle and clear o_level_valid; next state ARM.
REQ-031 ARM SHALL last exactly one cycle ignoring i_sz_rdy (map rdy drops one cycle after the pulse); next state WAIT.
REQ-032 WAIT SHALL remain until i_sz_rdy=1, then set o_level_valid=1 and return to RUN.
REQ-033 i_regen_req outside RUN SHALL be ignored (not queued).
REQ-034 o_regen_busy SHALL equal (state != RUN) or pending flag.

Reset
REQ-035 On arst_n low: state RUN, pending 0, o_level_valid 0, round-robin pointer 0, pipeline valids 0, all outputs 0 including o_sz_x/o_sz_y.
REQ-036 Reset mid-operation SHALL discard in-flight queries; no o_resp_valid after reset release until a new accept.

Structure
REQ-037 FSM state enum and the SCREEN_WIDTH/SCREEN_HEIGHT/BLOCK_SIZE defaults SHALL live in the shared game package.
REQ-038 A round-robin arbiter sub-module rr_arbiter (NUM_REQ requests in, one-hot grant out, advance input) SHALL be used.

Verification
REQ-039 After reset, pulse i_regen_req, map rdy low 5 cycles -> one o_sz_regenerate pulse, o_level_valid=1 exactly the cycle after i_sz_rdy returns high.
REQ-040 All 4 requesters valid continuously -> grants 0,1,2,3,0 on consecutive cycles; each o_resp_valid exactly 2 cycles after its accept.
REQ-041 Requester 1 queries (400,10) and (10,600) with i_sz_is_safe forced 1 -> o_resp_safe=0 both.
REQ-042 Requester 2 queries (45,65) with map returning 1 -> o_sz_x=45, o_sz_y=65 at t+1, o_resp_valid[2]=1, o_resp_safe=1 at t+2.
REQ-043 i_regen_req with two queries in flight -> both responses delivered, then o_sz_regenerate; no o_req_ready until WAIT exits.
REQ-044 arst_n asserted one cycle after an accept -> no o_resp_valid, all outputs 0, o_level_valid=0.
